// File: rtl/aes_rkey_buf.sv
// Round-key buffer for AES-128: captures the 11 expanded round keys and
// replays them forward (encrypt) or in reverse (decrypt) with one-cycle latency.
module aes_rkey_buf #(
  parameter int NUM_KEYS = 11,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             start,
  input  logic             key_vld,
  input  logic [127:0]     key_i,
  input  logic             rd_req,
  input  logic             rd_dir,
  output logic [127:0]     rd_key_o,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic             rd_vld_o,
  output logic             rd_last_o,
  output logic             ready_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, READY = 2'd2} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] wr_ptr_r, rd_ptr_r, rd_pos_s, rd_ptr_nxt_s, rd_idx_r;
  logic             dir_r, at_bnd_r, rd_dir_eff_s, rd_end_s;
  logic             wr_s, rd_acc_s, err_set_s;
  logic             ready_r, rd_vld_r, rd_last_r, err_r;
  logic [127:0]     rd_key_r;
  logic [127:0]     mem_r [NUM_KEYS];

  // State register; ready follows the registered state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
    end else if (en) begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == READY);
    end
  end

  // Next-state logic; start restarts capture from any state
  always_comb begin
    state_nxt_s = state_r;
    if (en && start) begin
      state_nxt_s = FILL;
    end else if (en) begin
      case (state_r)
        FILL: begin
          if (key_vld && (wr_ptr_r == LAST_IDX)) begin
            state_nxt_s = READY;
          end else begin
            state_nxt_s = FILL;
          end
        end
        default: state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Per-state actions; start masks any simultaneous write, read or error
  always_comb begin
    wr_s      = 1'b0;
    rd_acc_s  = 1'b0;
    err_set_s = 1'b0;
    if (en && !start) begin
      case (state_r)
        IDLE:    err_set_s = rd_req;
        FILL: begin
          wr_s      = key_vld;
          err_set_s = rd_req;
        end
        READY: begin
          rd_acc_s  = rd_req;
          err_set_s = key_vld;
        end
        default: err_set_s = 1'b0;
      endcase
    end else begin
      wr_s = 1'b0;
    end
  end

  // At a block boundary the direction and first position come from rd_dir
  always_comb begin
    rd_dir_eff_s = at_bnd_r ? rd_dir : dir_r;
    if (at_bnd_r) begin
      rd_pos_s = rd_dir ? LAST_IDX : ZERO_IDX;
    end else begin
      rd_pos_s = rd_ptr_r;
    end
    rd_end_s     = rd_dir_eff_s ? (rd_pos_s == ZERO_IDX) : (rd_pos_s == LAST_IDX);
    rd_ptr_nxt_s = rd_dir_eff_s ? (rd_pos_s - ONE_IDX) : (rd_pos_s + ONE_IDX);
  end

  // Write pointer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= ZERO_IDX;
    end else if (en) begin
      if (start) begin
        wr_ptr_r <= ZERO_IDX;
      end else if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_IDX;
      end
    end
  end

  // Key storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= key_i;
    end
  end

  // Read pointer, boundary flag and latched direction
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_r <= ZERO_IDX;
      at_bnd_r <= 1'b1;
      dir_r    <= 1'b0;
    end else if (en) begin
      if (start) begin
        rd_ptr_r <= ZERO_IDX;
        at_bnd_r <= 1'b1;
      end else if (rd_acc_s) begin
        dir_r <= rd_dir_eff_s;
        if (rd_end_s) begin
          rd_ptr_r <= ZERO_IDX;
          at_bnd_r <= 1'b1;
        end else begin
          rd_ptr_r <= rd_ptr_nxt_s;
          at_bnd_r <= 1'b0;
        end
      end
    end
  end

  // Registered read outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_key_r  <= 128'd0;
      rd_idx_r  <= ZERO_IDX;
      rd_vld_r  <= 1'b0;
      rd_last_r <= 1'b0;
    end else if (en) begin
      rd_vld_r  <= rd_acc_s;
      rd_last_r <= rd_acc_s & rd_end_s;
      if (rd_acc_s) begin
        rd_key_r <= mem_r[rd_pos_s];
        rd_idx_r <= rd_pos_s;
      end
    end
  end

  // Sticky protocol error, cleared only by start
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_r <= 1'b0;
    end else if (en) begin
      if (start) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign rd_key_o  = rd_key_r;
  assign rd_idx_o  = rd_idx_r;
  assign rd_vld_o  = rd_vld_r;
  assign rd_last_o = rd_last_r;
  assign ready_o   = ready_r;
  assign err_o     = err_r;

endmodule

// File: tb/tb_aes_rkey_buf.sv
// Directed bench for aes_rkey_buf using the FIPS-197 AES-128 key expansion
// of 2b7e151628aed2a6abf7158809cf4f3c.
module tb_aes_rkey_buf;

  logic         clk = 1'b0;
  logic         nrst, en, start, key_vld, rd_req, rd_dir;
  logic [127:0] key_i;
  logic [127:0] rd_key_o;
  logic [3:0]   rd_idx_o;
  logic         rd_vld_o, rd_last_o, ready_o, err_o;

  logic [127:0] keys [11];
  int vectors = 0;
  int miscompares = 0;

  aes_rkey_buf #(.NUM_KEYS(11), .IDX_W(4)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .key_vld(key_vld),
    .key_i(key_i), .rd_req(rd_req), .rd_dir(rd_dir), .rd_key_o(rd_key_o),
    .rd_idx_o(rd_idx_o), .rd_vld_o(rd_vld_o), .rd_last_o(rd_last_o),
    .ready_o(ready_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_keys(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      key_vld = 1'b1;
      key_i   = keys[i];
      cyc();
    end
    key_vld = 1'b0;
  endtask

  initial begin
    keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    nrst = 1'b1; en = 1'b1; start = 1'b0; key_vld = 1'b0;
    rd_req = 1'b0; rd_dir = 1'b0; key_i = 128'd0;
    #1 nrst = 1'b0;
    cyc(); cyc();
    chk("rst_vld",   128'(rd_vld_o),  128'd0);
    chk("rst_ready", 128'(ready_o),   128'd0);
    chk("rst_err",   128'(err_o),     128'd0);
    chk("rst_key",   rd_key_o,        128'd0);
    chk("rst_last",  128'(rd_last_o), 128'd0);
    nrst = 1'b1;
    cyc();

    // Forward capture and read
    start = 1'b1; cyc(); start = 1'b0;
    write_keys(0, 9);
    chk("ready_before_last", 128'(ready_o), 128'd0);
    write_keys(10, 10);
    chk("ready_after_last", 128'(ready_o), 128'd1);
    rd_req = 1'b1; rd_dir = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk($sformatf("fwd_vld%0d", i),  128'(rd_vld_o),  128'd1);
      chk($sformatf("fwd_idx%0d", i),  128'(rd_idx_o),  128'(i));
      chk($sformatf("fwd_key%0d", i),  rd_key_o,        keys[i]);
      chk($sformatf("fwd_last%0d", i), 128'(rd_last_o), 128'(i == 10));
    end
    rd_req = 1'b0; cyc();
    chk("fwd_idle_vld", 128'(rd_vld_o), 128'd0);
    chk("fwd_err",      128'(err_o),    128'd0);

    // Overflow write in READY
    key_vld = 1'b1; key_i = 128'hdeadbeefdeadbeefdeadbeefdeadbeef; cyc(); key_vld = 1'b0;
    chk("ovf_err",   128'(err_o),   128'd1);
    chk("ovf_ready", 128'(ready_o), 128'd1);

    // Reverse read with gaps and a mid-block direction flip
    for (int n = 0; n < 11; n++) begin
      rd_req = 1'b1; rd_dir = (n >= 3) ? 1'b0 : 1'b1;
      cyc();
      chk($sformatf("rev_idx%0d", n),  128'(rd_idx_o),  128'(10 - n));
      chk($sformatf("rev_key%0d", n),  rd_key_o,        keys[10 - n]);
      chk($sformatf("rev_last%0d", n), 128'(rd_last_o), 128'(n == 10));
      rd_req = 1'b0;
      cyc();
      chk($sformatf("rev_gap%0d", n),  128'(rd_vld_o),  128'd0);
    end
    rd_req = 1'b1; rd_dir = 1'b0; cyc();
    chk("resample_idx",  128'(rd_idx_o),  128'd0);
    chk("resample_last", 128'(rd_last_o), 128'd0);

    // Enable low freezes outputs and pointer
    cyc();
    chk("en_pre_idx", 128'(rd_idx_o), 128'd1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("en_frz_vld%0d", i), 128'(rd_vld_o), 128'd1);
      chk($sformatf("en_frz_idx%0d", i), 128'(rd_idx_o), 128'd1);
    end
    en = 1'b1; cyc();
    chk("en_resume_idx", 128'(rd_idx_o), 128'd2);
    chk("en_resume_key", rd_key_o,       keys[2]);

    // Start during a READY read
    start = 1'b1; cyc(); start = 1'b0; rd_req = 1'b0;
    chk("start_rd_vld", 128'(rd_vld_o), 128'd0);
    chk("start_ready",  128'(ready_o),  128'd0);
    chk("start_err",    128'(err_o),    128'd0);

    // Start with simultaneous key_vld drops that key
    start = 1'b1; key_vld = 1'b1; key_i = 128'h0123456789abcdef0123456789abcdef;
    cyc(); start = 1'b0; key_vld = 1'b0;
    chk("drop_err", 128'(err_o), 128'd0);
    write_keys(0, 4);
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    chk("fill_rd_vld", 128'(rd_vld_o), 128'd0);
    chk("fill_rd_err", 128'(err_o),    128'd1);
    write_keys(5, 10);
    chk("refill_ready", 128'(ready_o), 128'd1);
    chk("err_sticky",   128'(err_o),   128'd1);
    rd_req = 1'b1; rd_dir = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk($sformatf("drop_key%0d", i), rd_key_o, keys[i]);
    end
    rd_req = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_clr_err", 128'(err_o), 128'd0);

    // Async reset mid-FILL
    write_keys(0, 2);
    #2 nrst = 1'b0;
    #1;
    chk("arst_ready", 128'(ready_o), 128'd0);
    chk("arst_vld",   128'(rd_vld_o), 128'd0);
    chk("arst_err",   128'(err_o),    128'd0);
    chk("arst_key",   rd_key_o,       128'd0);
    nrst = 1'b1;
    cyc();
    write_keys(3, 10);
    cyc();
    chk("arst_no_ready", 128'(ready_o), 128'd0);

    // Full recapture after reset
    start = 1'b1; cyc(); start = 1'b0;
    write_keys(0, 10);
    chk("recap_ready", 128'(ready_o), 128'd1);
    rd_req = 1'b1; rd_dir = 1'b1; cyc(); rd_req = 1'b0;
    chk("recap_idx", 128'(rd_idx_o), 128'd10);
    chk("recap_key", rd_key_o,       keys[10]);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
